// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_reg_arbiter
// Description : Round-robin req/gnt arbiter that owns every write to a shared
//               W-bit register; a dedicated clear requester has top priority.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_reg_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    input  logic                 clr_req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 clr_ack,
    output logic [W-1:0]         q,
    output logic                 busy
);

    localparam int c_IDW = $clog2(N);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_CLR  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_IDW-1:0] r_ptr;
    logic [N-1:0]     r_gnt;
    logic [c_IDW-1:0] r_gnt_id;
    logic             r_clr_ack;
    logic [W-1:0]     r_q;

    logic             w_found;
    logic [c_IDW-1:0] w_winner;
    logic [W-1:0]     w_lane;
    logic [N-1:0]     w_gnt_nxt;
    logic [c_IDW-1:0] w_gnt_id_nxt;
    logic             w_clr_ack_nxt;
    logic [W-1:0]     w_q_nxt;
    logic [c_IDW-1:0] w_ptr_nxt;

    // First requester found scanning upward from the pointer, wrapping at N.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % N]) begin
                w_found  = 1'b1;
                w_winner = c_IDW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_lane = wdata[int'(w_winner)*W +: W];

    always_ff @(posedge clk) begin
        if (R) begin
            r_state   <= c_ST_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_clr_ack <= 1'b0;
            r_q       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_clr_ack <= w_clr_ack_nxt;
            r_q       <= w_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (clr_req)      w_state_nxt = c_ST_CLR;
                else if (w_found) w_state_nxt = c_ST_HOLD;
            end
            c_ST_HOLD: if (!req[r_gnt_id]) w_state_nxt = c_ST_IDLE;
            c_ST_CLR:  if (!clr_req)       w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless an edge event applies.
    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_clr_ack_nxt = r_clr_ack;
        w_q_nxt       = r_q;
        w_ptr_nxt     = r_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (clr_req) begin
                    w_q_nxt       = '0;
                    w_clr_ack_nxt = 1'b1;
                end else if (w_found) begin
                    w_gnt_nxt    = {{(N-1){1'b0}}, 1'b1} << w_winner;
                    w_gnt_id_nxt = w_winner;
                    w_q_nxt      = w_lane;
                    w_ptr_nxt    = (w_winner == c_IDW'(N-1)) ? '0 : w_winner + 1'b1;
                end
            end
            c_ST_HOLD: if (!req[r_gnt_id]) w_gnt_nxt = '0;
            c_ST_CLR:  if (!clr_req)       w_clr_ack_nxt = 1'b0;
            default: ;
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign clr_ack = r_clr_ack;
    assign q       = r_q;
    assign busy    = (|r_gnt) | r_clr_ack;

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_reg_arbiter
// Description : Directed-vector bench; expected grant/clear events are queued
//               and matched by a monitor whenever the outputs present a new one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           R;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic           clr_req;
    logic [N-1:0]   gnt;
    logic [1:0]     gnt_id;
    logic           clr_ack;
    logic [W-1:0]   q;
    logic           busy;

    shared_reg_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .R       (R),
        .req     (req),
        .wdata   (wdata),
        .clr_req (clr_req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .clr_ack (clr_ack),
        .q       (q),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] g;
        logic [1:0]   id;
        logic         c;
        logic [W-1:0] qq;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [N-1:0] g, input logic [1:0] id, input logic c,
                             input logic [W-1:0] qq);
        sb.push_back('{g, id, c, qq});
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] g, input logic c,
                           input logic [W-1:0] qq, input logic b);
        chk({tag, ".gnt"},  32'(gnt),     32'(g));
        chk({tag, ".clr"},  32'(clr_ack), 32'(c));
        chk({tag, ".q"},    32'(q),       32'(qq));
        chk({tag, ".busy"}, 32'(busy),    32'(b));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new non-idle output pattern is one grant or clear event.
    logic [N:0] mon_prev = '0;
    logic [N:0] mon_cur;
    exp_t       mon_e;
    always @(negedge clk) begin
        mon_cur = {gnt, clr_ack};
        if ((|mon_cur) === 1'b1 && mon_cur !== mon_prev) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ev.unexpected: got gnt=%b clr_ack=%b, expected no event", gnt, clr_ack);
            end else begin
                mon_e = sb.pop_front();
                chk("ev.gnt", 32'(gnt), 32'(mon_e.g));
                chk("ev.clr", 32'(clr_ack), 32'(mon_e.c));
                chk("ev.q", 32'(q), 32'(mon_e.qq));
                chk("ev.excl", 32'($onehot0(gnt) && !(|gnt && clr_ack)), 32'd1);
                if (!mon_e.c) chk("ev.id", 32'(gnt_id), 32'(mon_e.id));
            end
        end
        mon_prev = mon_cur;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    logic [7:0] rr_q [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        R       = 1'b1;
        req     = 4'b1111;
        clr_req = 1'b1;
        wdata   = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset dominates pending requests and clear
        tick; chk_out("rst1", 4'b0000, 1'b0, 8'h00, 1'b0);
        tick; chk_out("rst2", 4'b0000, 1'b0, 8'h00, 1'b0);
        R       = 1'b0;
        clr_req = 1'b0;

        // Round-robin 0,1,2,3,0 with a one-cycle drop by each winner
        for (int i = 0; i < 5; i++) begin
            expect_ev(4'(1 << (i % 4)), 2'(i % 4), 1'b0, rr_q[i]);
            tick;
            chk("rr.gnt", 32'(gnt), 32'(1 << (i % 4)));
            req[i % 4] = 1'b0;
            tick;
            chk("rr.gap", 32'(gnt), 32'd0);
            req = 4'b1111;
        end
        req = 4'b0000;

        // Single load; wdata change during HOLD must not reach q
        wdata[23:16] = 8'hA5;
        expect_ev(4'b0100, 2'd2, 1'b0, 8'hA5);
        req = 4'b0100;
        tick; chk_out("load.t", 4'b0100, 1'b0, 8'hA5, 1'b1);
        chk("load.id", 32'(gnt_id), 32'd2);
        wdata[23:16] = 8'h5A;
        tick; chk_out("load.hold", 4'b0100, 1'b0, 8'hA5, 1'b1);
        tick;
        req = 4'b0000;
        tick; chk_out("load.rel", 4'b0000, 1'b0, 8'hA5, 1'b0);

        // Load 3C via requester 3 so the pointer wraps to 0
        wdata[31:24] = 8'h3C;
        expect_ev(4'b1000, 2'd3, 1'b0, 8'h3C);
        req = 4'b1000;
        tick;
        req = 4'b0000;
        tick; chk_out("pre.rel", 4'b0000, 1'b0, 8'h3C, 1'b0);

        // Clear beats a simultaneous request
        expect_ev(4'b0000, 2'd0, 1'b1, 8'h00);
        req     = 4'b0010;
        clr_req = 1'b1;
        tick; chk_out("clr.pri", 4'b0000, 1'b1, 8'h00, 1'b1);
        clr_req = 1'b0;
        req     = 4'b0011;
        tick; chk_out("clr.exit", 4'b0000, 1'b0, 8'h00, 1'b0);
        expect_ev(4'b0001, 2'd0, 1'b0, 8'h11);
        tick; chk("clr.ptr0", 32'(gnt_id), 32'd0);
        req = 4'b0010;
        tick;
        expect_ev(4'b0010, 2'd1, 1'b0, 8'h22);
        tick; chk("clr.req1", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick;

        // Clear raised during HOLD waits for release
        wdata[31:24] = 8'hC3;
        expect_ev(4'b1000, 2'd3, 1'b0, 8'hC3);
        req = 4'b1000;
        tick;
        clr_req = 1'b1;
        tick; chk_out("def.h1", 4'b1000, 1'b0, 8'hC3, 1'b1);
        tick; chk_out("def.h2", 4'b1000, 1'b0, 8'hC3, 1'b1);
        req = 4'b0000;
        tick; chk_out("def.rel", 4'b0000, 1'b0, 8'hC3, 1'b0);
        expect_ev(4'b0000, 2'd0, 1'b1, 8'h00);
        tick; chk_out("def.clr", 4'b0000, 1'b1, 8'h00, 1'b1);
        clr_req = 1'b0;
        tick; chk_out("def.exit", 4'b0000, 1'b0, 8'h00, 1'b0);

        // Reset in HOLD, then fresh grant picks up current wdata
        wdata[15:8] = 8'h77;
        expect_ev(4'b0010, 2'd1, 1'b0, 8'h77);
        req = 4'b0010;
        tick; chk("rsth.q", 32'(q), 32'h77);
        R = 1'b1;
        wdata[15:8] = 8'h88;
        tick; chk_out("rsth.rst", 4'b0000, 1'b0, 8'h00, 1'b0);
        R = 1'b0;
        expect_ev(4'b0010, 2'd1, 1'b0, 8'h88);
        tick; chk_out("rsth.regr", 4'b0010, 1'b0, 8'h88, 1'b1);
        req = 4'b0000;
        tick;
        tick;

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
